// File: rtl/mc_fetch_unit.sv
// -----------------------------------------------------------------------------
// mc_fetch_unit
//
// Instruction-fetch engine for the multicycle CPU. Owns the program counter,
// walks BYTES_PER_INSTR consecutive byte addresses over a req/ack handshake to
// a variable-latency byte-wide memory, and assembles the bytes LSB-first into
// one instruction word. The completed word is flagged with a one-cycle
// instr_valid pulse, and the PC advances past the instruction.
//
// Parameters
//   ADDR_WIDTH       width of the PC and memory address
//   BYTES_PER_INSTR  bytes per instruction word (1..8)
//   RESET_PC         PC value after reset
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   fetch_req    start a fetch (sampled only while idle)
//   pc_load      load pc_target into the PC; aborts a fetch in progress
//   pc_target    branch/jump target
//   mem_req      memory read request, held until acknowledged
//   mem_addr     byte address of the current request
//   mem_ack      read data valid this cycle (ignored while mem_req is low)
//   mem_rdata    read byte
//   busy         high while fetching and in the completion cycle
//   instr_valid  one-cycle pulse: instr has just been completed
//   instr        assembled instruction word
//   pc           address of the next instruction
// -----------------------------------------------------------------------------
module mc_fetch_unit #(
  parameter int unsigned             ADDR_WIDTH      = 8,
  parameter int unsigned             BYTES_PER_INSTR = 4,
  parameter logic [ADDR_WIDTH-1:0]   RESET_PC        = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         fetch_req,
  input  logic                         pc_load,
  input  logic [ADDR_WIDTH-1:0]        pc_target,
  output logic                         mem_req,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic                         mem_ack,
  input  logic [7:0]                   mem_rdata,
  output logic                         busy,
  output logic                         instr_valid,
  output logic [8*BYTES_PER_INSTR-1:0] instr,
  output logic [ADDR_WIDTH-1:0]        pc
);

  // Byte counter is at least one bit wide so BYTES_PER_INSTR == 1 still works.
  localparam int unsigned CNT_WIDTH   = (BYTES_PER_INSTR > 1) ? $clog2(BYTES_PER_INSTR) : 1;
  localparam int unsigned INSTR_WIDTH = 8 * BYTES_PER_INSTR;

  localparam logic [CNT_WIDTH-1:0]  LAST_CNT     = CNT_WIDTH'(BYTES_PER_INSTR - 1);
  localparam logic [ADDR_WIDTH-1:0] INSTR_STRIDE = ADDR_WIDTH'(BYTES_PER_INSTR);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;

    case (state_q)
      IDLE: begin
        // A jump wins over a fetch issued in the same cycle.
        if (pc_load) begin
          pc_d = pc_target;
        end else if (fetch_req) begin
          base_d  = pc_q;
          cnt_d   = '0;
          state_d = FETCH;
        end
      end

      FETCH: begin
        // Abort: an ack arriving together with pc_load is dropped, and bytes
        // already captured are left in place.
        if (pc_load) begin
          pc_d    = pc_target;
          state_d = IDLE;
        end else if (mem_ack) begin
          for (int unsigned k = 0; k < BYTES_PER_INSTR; k++) begin
            if (cnt_q == CNT_WIDTH'(k)) begin
              instr_d[8*k +: 8] = mem_rdata;
            end
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            pc_d    = base_q + INSTR_STRIDE;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        // fetch_req is not looked at here; a new fetch starts only from IDLE.
        if (pc_load) begin
          pc_d = pc_target;
        end
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      base_q  <= RESET_PC;
      cnt_q   <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Decoded straight from the state register, so an asynchronous reset drops
  // mem_req without waiting for a clock edge.
  assign mem_req     = (state_q == FETCH);
  assign busy        = (state_q == FETCH) || (state_q == DONE);
  assign instr_valid = (state_q == DONE);

  // Address wraps modulo 2^ADDR_WIDTH; stays put across wait states because
  // base and cnt only move on an ack.
  assign mem_addr = base_q + ADDR_WIDTH'(cnt_q);

  assign instr = instr_q;
  assign pc    = pc_q;

endmodule

// File: tb/tb_mc_fetch_unit.sv
module tb_mc_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // DUT A: 8-bit address, 4-byte instructions, reset PC 0
  logic        fetch_req_a, pc_load_a, mem_ack_a;
  logic [7:0]  pc_target_a, mem_rdata_a;
  logic        mem_req_a, busy_a, instr_valid_a;
  logic [7:0]  mem_addr_a, pc_a;
  logic [31:0] instr_a;

  // DUT B: 12-bit address, 1-byte instructions, reset PC 0x123
  logic        fetch_req_b, pc_load_b, mem_ack_b;
  logic [11:0] pc_target_b;
  logic [7:0]  mem_rdata_b;
  logic        mem_req_b, busy_b, instr_valid_b;
  logic [11:0] mem_addr_b, pc_b;
  logic [7:0]  instr_b;

  mc_fetch_unit #(.ADDR_WIDTH(8), .BYTES_PER_INSTR(4), .RESET_PC(8'h00)) u_dut_a (
    .clk(clk), .reset(reset), .fetch_req(fetch_req_a), .pc_load(pc_load_a),
    .pc_target(pc_target_a), .mem_req(mem_req_a), .mem_addr(mem_addr_a),
    .mem_ack(mem_ack_a), .mem_rdata(mem_rdata_a), .busy(busy_a),
    .instr_valid(instr_valid_a), .instr(instr_a), .pc(pc_a)
  );

  mc_fetch_unit #(.ADDR_WIDTH(12), .BYTES_PER_INSTR(1), .RESET_PC(12'h123)) u_dut_b (
    .clk(clk), .reset(reset), .fetch_req(fetch_req_b), .pc_load(pc_load_b),
    .pc_target(pc_target_b), .mem_req(mem_req_b), .mem_addr(mem_addr_b),
    .mem_ack(mem_ack_b), .mem_rdata(mem_rdata_b), .busy(busy_b),
    .instr_valid(instr_valid_b), .instr(instr_b), .pc(pc_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  mem_a [256];
  int          cur_waits [4];
  logic [7:0]  obs_addr [$];
  int          obs_valid_cyc;
  int          obs_cycles;
  logic [31:0] model_instr_a;
  logic [11:0] model_pc_b;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_a(input logic [7:0] tgt);
    pc_load_a   = 1'b1;
    pc_target_a = tgt;
    tick();
    pc_load_a   = 1'b0;
  endtask

  // Memory responder for DUT A: byte k is acked after cur_waits[k] idle cycles.
  // Optionally raises pc_load together with the ack of byte abort_byte.
  // Returns at the negedge of the DONE cycle, or of the first cycle with no
  // request after an abort.
  task automatic fetch_a(input int abort_byte, input logic [7:0] abort_tgt);
    int k;
    int waited;
    int cyc;
    k = 0;
    waited = 0;
    obs_addr.delete();
    obs_valid_cyc = -1;
    fetch_req_a = 1'b1;
    tick();
    fetch_req_a = 1'b0;
    for (cyc = 1; cyc <= 60; cyc++) begin
      mem_ack_a = 1'b0;
      pc_load_a = 1'b0;
      if (instr_valid_a) begin
        obs_valid_cyc = cyc;
        break;
      end
      if (!mem_req_a) break;
      obs_addr.push_back(mem_addr_a);
      if (k < 4 && waited == cur_waits[k]) begin
        mem_ack_a   = 1'b1;
        mem_rdata_a = mem_a[mem_addr_a];
        if (k == abort_byte) begin
          pc_load_a   = 1'b1;
          pc_target_a = abort_tgt;
        end
        k++;
        waited = 0;
      end else begin
        waited++;
      end
      tick();
    end
    obs_cycles = cyc;
    mem_ack_a = 1'b0;
    pc_load_a = 1'b0;
  endtask

  // Expected address trace: byte k of the instruction at base is requested
  // for cur_waits[k]+1 consecutive cycles.
  function automatic bit seq_ok(input logic [7:0] base, input int nbytes);
    int idx;
    logic [7:0] a;
    idx = 0;
    for (int k = 0; k < nbytes; k++) begin
      a = base + 8'(k);
      for (int r = 0; r <= cur_waits[k]; r++) begin
        if (idx >= obs_addr.size()) return 1'b0;
        if (obs_addr[idx] !== a) return 1'b0;
        idx++;
      end
    end
    return idx == obs_addr.size();
  endfunction

  // Word after the first nbytes of the instruction at base have been written.
  function automatic logic [31:0] model_word(input logic [7:0] base, input int nbytes,
                                             input logic [31:0] old);
    logic [31:0] w;
    logic [7:0]  a;
    w = old;
    for (int k = 0; k < nbytes; k++) begin
      a = base + 8'(k);
      w[8*k +: 8] = mem_a[a];
    end
    return w;
  endfunction

  task automatic test_reset();
    n_cmp++; if (pc_a !== 8'h00) begin n_bad++; $display("FAIL reset_pc_a: got %h want 00", pc_a); end
    n_cmp++; if (instr_a !== 32'h0) begin n_bad++; $display("FAIL reset_instr_a: got %h want 0", instr_a); end
    n_cmp++; if ({mem_req_a, busy_a, instr_valid_a} !== 3'b000) begin n_bad++;
      $display("FAIL reset_ctrl_a: got %b want 000", {mem_req_a, busy_a, instr_valid_a}); end
    n_cmp++; if (pc_b !== 12'h123) begin n_bad++; $display("FAIL reset_pc_b: got %h want 123", pc_b); end
    n_cmp++; if ({mem_req_b, busy_b, instr_valid_b} !== 3'b000) begin n_bad++;
      $display("FAIL reset_ctrl_b: got %b want 000", {mem_req_b, busy_b, instr_valid_b}); end
  endtask

  task automatic test_basic();
    for (int k = 0; k < 4; k++) mem_a[k] = 8'h10 + 8'(k);
    cur_waits = '{0, 0, 0, 0};
    fetch_a(-1, 8'h00);
    n_cmp++; if (!seq_ok(8'h00, 4)) begin n_bad++; $display("FAIL basic_addr: got %p want 00..03", obs_addr); end
    n_cmp++; if (obs_valid_cyc != 5) begin n_bad++; $display("FAIL basic_latency: got %0d want 5", obs_valid_cyc); end
    n_cmp++; if (instr_a !== 32'h13121110) begin n_bad++; $display("FAIL basic_instr: got %h want 13121110", instr_a); end
    n_cmp++; if (pc_a !== 8'h04) begin n_bad++; $display("FAIL basic_pc: got %h want 04", pc_a); end
    n_cmp++; if ({busy_a, mem_req_a} !== 2'b10) begin n_bad++; $display("FAIL basic_done_ctrl: got %b want 10", {busy_a, mem_req_a}); end
    model_instr_a = 32'h13121110;
    tick();
    n_cmp++; if ({instr_valid_a, busy_a} !== 2'b00) begin n_bad++; $display("FAIL basic_pulse: got %b want 00", {instr_valid_a, busy_a}); end
    n_cmp++; if (instr_a !== model_instr_a) begin n_bad++; $display("FAIL basic_hold: got %h want %h", instr_a, model_instr_a); end
  endtask

  task automatic test_wait_states();
    load_a(8'h00);
    cur_waits = '{0, 2, 0, 0};
    fetch_a(-1, 8'h00);
    n_cmp++; if (!seq_ok(8'h00, 4)) begin n_bad++; $display("FAIL wait_addr: got %p want 00,01x3,02,03", obs_addr); end
    n_cmp++; if (obs_valid_cyc != 7) begin n_bad++; $display("FAIL wait_latency: got %0d want 7", obs_valid_cyc); end
    n_cmp++; if (instr_a !== 32'h13121110) begin n_bad++; $display("FAIL wait_instr: got %h want 13121110", instr_a); end
    tick();
  endtask

  task automatic test_wrap();
    logic [31:0] exp_w;
    load_a(8'hFE);
    cur_waits = '{0, 0, 0, 0};
    exp_w = model_word(8'hFE, 4, model_instr_a);
    fetch_a(-1, 8'h00);
    n_cmp++; if (!seq_ok(8'hFE, 4)) begin n_bad++; $display("FAIL wrap_addr: got %p want fe,ff,00,01", obs_addr); end
    n_cmp++; if (pc_a !== 8'h02) begin n_bad++; $display("FAIL wrap_pc: got %h want 02", pc_a); end
    n_cmp++; if (instr_a !== exp_w) begin n_bad++; $display("FAIL wrap_instr: got %h want %h", instr_a, exp_w); end
    model_instr_a = exp_w;
    tick();
  endtask

  task automatic test_abort();
    logic [31:0] exp_w;
    load_a(8'h80);
    cur_waits = '{0, 0, 0, 0};
    exp_w = model_word(8'h80, 2, model_instr_a);
    fetch_a(2, 8'h40);
    n_cmp++; if (obs_valid_cyc != -1) begin n_bad++; $display("FAIL abort_novalid: got %0d want -1", obs_valid_cyc); end
    n_cmp++; if (obs_cycles != 4) begin n_bad++; $display("FAIL abort_req_drop: got %0d want 4", obs_cycles); end
    n_cmp++; if (!seq_ok(8'h80, 3)) begin n_bad++; $display("FAIL abort_addr: got %p want 80..82", obs_addr); end
    n_cmp++; if (pc_a !== 8'h40) begin n_bad++; $display("FAIL abort_pc: got %h want 40", pc_a); end
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL abort_idle: got %b want 0", busy_a); end
    n_cmp++; if (instr_a !== exp_w) begin n_bad++; $display("FAIL abort_partial: got %h want %h", instr_a, exp_w); end
    model_instr_a = exp_w;
    exp_w = model_word(8'h40, 4, model_instr_a);
    fetch_a(-1, 8'h00);
    n_cmp++; if (!seq_ok(8'h40, 4)) begin n_bad++; $display("FAIL abort_next_addr: got %p want 40..43", obs_addr); end
    n_cmp++; if (instr_a !== exp_w) begin n_bad++; $display("FAIL abort_next_instr: got %h want %h", instr_a, exp_w); end
    n_cmp++; if (pc_a !== 8'h44) begin n_bad++; $display("FAIL abort_next_pc: got %h want 44", pc_a); end
    model_instr_a = exp_w;
    tick();
  endtask

  task automatic test_priority();
    fetch_req_a = 1'b1;
    pc_load_a   = 1'b1;
    pc_target_a = 8'h20;
    tick();
    fetch_req_a = 1'b0;
    pc_load_a   = 1'b0;
    n_cmp++; if (pc_a !== 8'h20) begin n_bad++; $display("FAIL prio_pc: got %h want 20", pc_a); end
    n_cmp++; if ({mem_req_a, busy_a} !== 2'b00) begin n_bad++; $display("FAIL prio_noreq: got %b want 00", {mem_req_a, busy_a}); end
    tick();
    n_cmp++; if (mem_req_a !== 1'b0) begin n_bad++; $display("FAIL prio_nolatch: got %b want 0", mem_req_a); end
  endtask

  // fetch_req held high from IDLE through DONE: the second fetch may start only
  // once the unit is back in IDLE.
  task automatic test_back_to_back();
    int first_v, idle_c, req2, v2;
    logic [7:0] addr2;
    first_v = -1; idle_c = -1; req2 = -1; v2 = -1; addr2 = 8'h00;
    fetch_req_a = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      tick();
      mem_ack_a = 1'b0;
      if (instr_valid_a) begin
        if (first_v < 0) first_v = cyc;
        else begin v2 = cyc; break; end
      end
      if (first_v >= 0 && cyc > first_v && idle_c < 0 && !busy_a) idle_c = cyc;
      if (first_v >= 0 && req2 < 0 && mem_req_a) begin
        req2 = cyc; addr2 = mem_addr_a; fetch_req_a = 1'b0;
      end
      if (mem_req_a) begin mem_ack_a = 1'b1; mem_rdata_a = mem_a[mem_addr_a]; end
    end
    mem_ack_a = 1'b0;
    fetch_req_a = 1'b0;
    n_cmp++; if (first_v != 5) begin n_bad++; $display("FAIL b2b_first_valid: got %0d want 5", first_v); end
    n_cmp++; if (idle_c != 6) begin n_bad++; $display("FAIL b2b_idle: got %0d want 6", idle_c); end
    n_cmp++; if (req2 != 7) begin n_bad++; $display("FAIL b2b_restart: got %0d want 7", req2); end
    n_cmp++; if (addr2 !== 8'h24) begin n_bad++; $display("FAIL b2b_addr: got %h want 24", addr2); end
    n_cmp++; if (v2 != 11) begin n_bad++; $display("FAIL b2b_second_valid: got %0d want 11", v2); end
    n_cmp++; if (pc_a !== 8'h28) begin n_bad++; $display("FAIL b2b_pc: got %h want 28", pc_a); end
    model_instr_a = model_word(8'h24, 4, model_instr_a);
    n_cmp++; if (instr_a !== model_instr_a) begin n_bad++; $display("FAIL b2b_instr: got %h want %h", instr_a, model_instr_a); end
    tick();
  endtask

  task automatic test_load_in_done();
    cur_waits = '{0, 0, 0, 0};
    fetch_a(-1, 8'h00);
    n_cmp++; if (obs_valid_cyc != 5) begin n_bad++; $display("FAIL done_load_valid: got %0d want 5", obs_valid_cyc); end
    model_instr_a = model_word(8'h28, 4, model_instr_a);
    pc_load_a   = 1'b1;
    pc_target_a = 8'h77;
    tick();
    pc_load_a = 1'b0;
    n_cmp++; if (pc_a !== 8'h77) begin n_bad++; $display("FAIL done_load_pc: got %h want 77", pc_a); end
    n_cmp++; if ({busy_a, instr_valid_a} !== 2'b00) begin n_bad++; $display("FAIL done_load_idle: got %b want 00", {busy_a, instr_valid_a}); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 16; it++) begin
      logic [7:0]  base, tgt;
      logic [31:0] exp_w;
      int          ab, lat;
      base = 8'($urandom);
      tgt  = 8'($urandom);
      for (int k = 0; k < 4; k++) begin
        cur_waits[k] = int'($urandom_range(0, 3));
        mem_a[8'($urandom)] = 8'($urandom);
      end
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      load_a(base);
      fetch_a(ab, tgt);
      if (ab < 0) begin
        exp_w = model_word(base, 4, model_instr_a);
        lat = 5;
        for (int k = 0; k < 4; k++) lat += cur_waits[k];
        n_cmp++; if (!seq_ok(base, 4)) begin n_bad++; $display("FAIL rnd_addr[%0d]: got %p base %h", it, obs_addr, base); end
        n_cmp++; if (obs_valid_cyc != lat) begin n_bad++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", it, obs_valid_cyc, lat); end
        n_cmp++; if (instr_a !== exp_w) begin n_bad++; $display("FAIL rnd_instr[%0d]: got %h want %h", it, instr_a, exp_w); end
        n_cmp++; if (pc_a !== base + 8'd4) begin n_bad++; $display("FAIL rnd_pc[%0d]: got %h want %h", it, pc_a, base + 8'd4); end
        model_instr_a = exp_w;
        tick();
      end else begin
        exp_w = model_word(base, ab, model_instr_a);
        n_cmp++; if (!seq_ok(base, ab + 1)) begin n_bad++; $display("FAIL rnd_abort_addr[%0d]: got %p base %h", it, obs_addr, base); end
        n_cmp++; if (obs_valid_cyc != -1) begin n_bad++; $display("FAIL rnd_abort_valid[%0d]: got %0d want -1", it, obs_valid_cyc); end
        n_cmp++; if (instr_a !== exp_w) begin n_bad++; $display("FAIL rnd_abort_instr[%0d]: got %h want %h", it, instr_a, exp_w); end
        n_cmp++; if (pc_a !== tgt) begin n_bad++; $display("FAIL rnd_abort_pc[%0d]: got %h want %h", it, pc_a, tgt); end
        model_instr_a = exp_w;
      end
    end
  endtask

  task automatic test_sweep_b();
    logic [7:0] rd;
    int w, waited, seen;
    bit addr_bad;
    pc_load_b   = 1'b1;
    pc_target_b = 12'hFFF;
    tick();
    pc_load_b  = 1'b0;
    model_pc_b = 12'hFFF;
    for (int it = 0; it < 6; it++) begin
      w = (it == 0) ? 0 : int'($urandom_range(0, 3));
      rd = 8'($urandom);
      waited = 0; seen = -1; addr_bad = 1'b0;
      fetch_req_b = 1'b1;
      for (int cyc = 1; cyc <= 20; cyc++) begin
        tick();
        fetch_req_b = 1'b0;
        mem_ack_b   = 1'b0;
        if (instr_valid_b) begin seen = cyc; break; end
        if (mem_req_b && mem_addr_b !== model_pc_b) addr_bad = 1'b1;
        if (mem_req_b) begin
          if (waited == w) begin mem_ack_b = 1'b1; mem_rdata_b = rd; end
          waited++;
        end
      end
      mem_ack_b = 1'b0;
      n_cmp++; if (seen != 2 + w) begin n_bad++; $display("FAIL b1_latency[%0d]: got %0d want %0d", it, seen, 2 + w); end
      n_cmp++; if (addr_bad) begin n_bad++; $display("FAIL b1_addr[%0d]: got a wrong address want %h", it, model_pc_b); end
      n_cmp++; if (instr_b !== rd) begin n_bad++; $display("FAIL b1_instr[%0d]: got %h want %h", it, instr_b, rd); end
      model_pc_b = model_pc_b + 12'd1;
      n_cmp++; if (pc_b !== model_pc_b) begin n_bad++; $display("FAIL b1_pc[%0d]: got %h want %h", it, pc_b, model_pc_b); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    fetch_req_a = 1'b1;
    fetch_req_b = 1'b1;
    tick();
    fetch_req_a = 1'b0;
    fetch_req_b = 1'b0;
    n_cmp++; if ({mem_req_a, mem_req_b} !== 2'b11) begin n_bad++; $display("FAIL arst_pre: got %b want 11", {mem_req_a, mem_req_b}); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if ({mem_req_a, busy_a, mem_req_b, busy_b} !== 4'b0000) begin n_bad++;
      $display("FAIL arst_req: got %b want 0000", {mem_req_a, busy_a, mem_req_b, busy_b}); end
    n_cmp++; if (pc_a !== 8'h00) begin n_bad++; $display("FAIL arst_pc_a: got %h want 00", pc_a); end
    n_cmp++; if (instr_a !== 32'h0) begin n_bad++; $display("FAIL arst_instr_a: got %h want 0", instr_a); end
    n_cmp++; if (pc_b !== 12'h123) begin n_bad++; $display("FAIL arst_pc_b: got %h want 123", pc_b); end
    @(negedge clk);
    reset = 1'b1;
    model_instr_a = 32'h0;
    tick();
    n_cmp++; if (mem_req_a !== 1'b0) begin n_bad++; $display("FAIL arst_after: got %b want 0", mem_req_a); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    fetch_req_a = 1'b0; pc_load_a = 1'b0; pc_target_a = '0; mem_ack_a = 1'b0; mem_rdata_a = '0;
    fetch_req_b = 1'b0; pc_load_b = 1'b0; pc_target_b = '0; mem_ack_b = 1'b0; mem_rdata_b = '0;
    for (int i = 0; i < 256; i++) mem_a[i] = 8'($urandom);
    model_instr_a = 32'h0;
    model_pc_b    = 12'h123;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    tick();
    test_reset();
    test_basic();
    test_wait_states();
    test_wrap();
    test_abort();
    test_priority();
    test_back_to_back();
    test_load_in_done();
    test_random();
    test_sweep_b();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_fetch_unit.md
Name: mc_fetch_unit

Overview:
- Parametrised instruction-fetch engine for the multicycle CPU. It replaces the fixed 4-write-enable byte assembly and the bare PC flop.
- Owns the PC and issues byte reads to a variable-latency byte-wide memory over a req/ack handshake. It assembles BYTES_PER_INSTR bytes into one instruction word, presents it with a one-cycle valid pulse, then advances the PC.
- Sits between the control FSM (fetch_req, pc_load) and the shared instruction/data memory port.

Parameters:
- ADDR_WIDTH, 8, width of PC and memory address.
- BYTES_PER_INSTR, 4, bytes per instruction. Legal range 1..8.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- fetch_req  input  1  start a fetch. Sampled only in IDLE.
- pc_load  input  1  load pc_target into PC. Aborts any fetch in progress.
- pc_target  input  ADDR_WIDTH  branch/jump target.
- mem_req  output  1  memory read request, held until acked.
- mem_addr  output  ADDR_WIDTH  byte address of the current request.
- mem_ack  input  1  read data valid this cycle. Ignored when mem_req=0.
- mem_rdata  input  8  read byte.
- busy  output  1  high in FETCH and DONE.
- instr_valid  output  1  one-cycle pulse, instr newly complete.
- instr  output  8*BYTES_PER_INSTR  assembled instruction word.
- pc  output  ADDR_WIDTH  current PC (address of next instruction).

Behaviour:
- Reset (reset=0, async): state=IDLE, pc=RESET_PC, instr=0, byte count=0, mem_req=0, instr_valid=0, busy=0.
- States:
  - IDLE: mem_req=0. If pc_load, set pc<=pc_target and stay in IDLE. Otherwise, if fetch_req, latch base<=pc, set cnt<=0, go to FETCH. pc_load has priority over fetch_req in the same cycle.
  - FETCH: mem_req=1, mem_addr=base+cnt, computed mod 2^ADDR_WIDTH. mem_addr is stable while waiting.
    - On mem_ack: instr[8*cnt+7:8*cnt]<=mem_rdata (byte k at base+k lands in bits 8k+7:8k, LSB-first). Then cnt<=cnt+1.
    - If cnt==BYTES_PER_INSTR-1, go to DONE and set pc<=base+BYTES_PER_INSTR, mod 2^ADDR_WIDTH.
    - With no ack, stay in FETCH with unlimited wait states.
  - DONE: instr_valid=1 for exactly this cycle, mem_req=0, then go to IDLE. fetch_req is ignored here. pc_load here sets pc<=pc_target; instr_valid is still asserted.
- Abort: pc_load in FETCH sets pc<=pc_target and goes to IDLE.
  - No instr_valid is produced. Bytes already written stay in instr, partially updated.
  - mem_req drops the next cycle. A mem_ack arriving in the same cycle as pc_load is discarded.
- Latency: with zero-wait memory (ack in every FETCH cycle), instr_valid is asserted BYTES_PER_INSTR+1 cycles after the fetch_req cycle. Each wait state adds 1 cycle.
- instr holds its value between fetches. It changes only on acked bytes.
- PC wrap: e.g. ADDR_WIDTH=8, base=0xFE, BYTES=4 reads addresses FE, FF, 00, 01, and pc becomes 0x02.
- Counter width is clog2(BYTES_PER_INSTR), minimum 1 bit.
- Reset asserted mid-FETCH returns everything to reset values immediately. mem_req drops asynchronously.

Test Plan:
- Reset/basic: RESET_PC=0, BYTES=4, zero-wait memory with mem[k]=0x10+k. Pulse fetch_req -> mem_addr 00,01,02,03 on consecutive cycles; instr=0x13121110; instr_valid pulses 5 cycles after req; pc=0x04.
- Wait states: ack delayed 2 cycles on byte 1 only -> mem_addr holds 0x01 for 3 cycles; instr_valid at cycle 7; instr unchanged in value; no duplicate byte writes.
- Wrap-around: pc_load with 0xFE in IDLE, then fetch -> addresses FE, FF, 00, 01; pc=0x02 after DONE.
- Abort: pc_load with 0x40 on the cycle of byte 2's ack -> byte 2 not written; no instr_valid; pc=0x40; state IDLE. The next fetch reads 40..43 correctly.
- Priority/ignore: fetch_req and pc_load=0x20 together in IDLE -> pc=0x20, no mem_req. fetch_req held through DONE -> the next fetch starts only from IDLE, one cycle after instr_valid.
- Parameter sweep: BYTES=1 and ADDR_WIDTH=12 -> one access per fetch, latency 2 cycles, pc increments by 1, wrap at 0xFFF->0x000. Async reset asserted mid-FETCH -> mem_req=0 without a clock edge.
